// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Overflow output is enabled by defining SERIAL_SUB_OVERFLOW_EN.
package serial_sub_pkg;

  localparam int SERIAL_SUB_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - b_in, b_out is the borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = x ^ y ^ b_in;
  assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, behind a start/busy/done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = SERIAL_SUB_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         b_in,
  output logic [N-1:0] d,
  output logic [N-1:0] b_out,
  output logic         busy,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic         done,
  output logic         ovf
`else
  output logic         done
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t          state, nxt;
  logic            accept, step, last;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    a_sr, b_sr, d_q, bo_q;
  logic            brw;
  logic            fs_d, fs_bo;
  logic            busy_q, done_q;

  full_subtractor u_fs (
    .x     (a_sr[0]),
    .y     (b_sr[0]),
    .b_in  (brw),
    .d     (fs_d),
    .b_out (fs_bo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? RUN : IDLE;
      RUN:     nxt = (cnt == CW'(N-1)) ? DONE : RUN;
      DONE:    nxt = start ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    step   = 1'b0;
    last   = 1'b0;
    case (state)
      IDLE, DONE: accept = start;
      RUN: begin
        step = 1'b1;
        last = (cnt == CW'(N-1));
      end
      default: ;
    endcase
  end

  // Operands shift right so the cell always sees bit 0; results land at index cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      brw  <= 1'b0;
      d_q  <= '0;
      bo_q <= '0;
      cnt  <= '0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      brw  <= b_in;
      d_q  <= '0;
      bo_q <= '0;
      cnt  <= '0;
    end else if (step) begin
      a_sr      <= a_sr >> 1;
      b_sr      <= b_sr >> 1;
      brw       <= fs_bo;
      d_q[cnt]  <= fs_d;
      bo_q[cnt] <= fs_bo;
      cnt       <= cnt + 1'b1;
    end
  end

  // Handshake flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (nxt == RUN);
      done_q <= (nxt == DONE);
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovf_q;

  // bo_q[N-2] was written on the previous RUN cycle; fs_bo is the final borrow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ovf_q <= 1'b0;
    else if (accept) ovf_q <= 1'b0;
    else if (last)   ovf_q <= bo_q[N-2] ^ fs_bo;
  end

  assign ovf = ovf_q;
`else
  logic unused_last;
  assign unused_last = last;
`endif

  assign d     = d_q;
  assign b_out = bo_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with randomized operands and an arithmetic reference model.
module tb_serial_subtractor;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic         b_in = 1'b0;
  logic [N-1:0] d, b_out;
  logic         busy, done;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .d     (d),
    .b_out (b_out),
    .busy  (busy),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .done  (done),
    .ovf   (ovf)
`else
    .done  (done)
`endif
  );

`ifndef SERIAL_SUB_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  // Reference model: plain modular / signed arithmetic.
  function automatic logic [N-1:0] ref_d(input int x, input int y, input int c);
    int r;
    r = (x - y - c) & ((1 << N) - 1);
    return r[N-1:0];
  endfunction

  function automatic logic [N-1:0] ref_bo(input int x, input int y, input int c);
    logic [N-1:0] r;
    int lim;
    for (int i = 0; i < N; i++) begin
      lim  = 1 << (i + 1);
      r[i] = ((x % lim) < ((y % lim) + c));
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int x, input int y, input int c);
    int sx, sy, r;
    sx = (x >= (1 << (N-1))) ? x - (1 << N) : x;
    sy = (y >= (1 << (N-1))) ? y - (1 << N) : y;
    r  = sx - sy - c;
    return (r < -(1 << (N-1))) || (r > (1 << (N-1)) - 1);
  endfunction

  // Drives one operation from IDLE/DONE, scrambling inputs while busy; records observations.
  task automatic do_op(input int x, input int y, input int c,
                       output int lat, output int bcnt, output logic overlap,
                       output logic timeout);
    @(negedge clk);
    a = x[N-1:0]; b = y[N-1:0]; b_in = c[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0; overlap = 1'b0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      a = N'($urandom); b = N'($urandom); b_in = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    if (busy && done) overlap = 1'b1;
    timeout = !done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (d !== '0)     begin errors++; $display("FAIL reset_d: got %b expected %b", d, 4'b0); end
    checks++; if (b_out !== '0) begin errors++; $display("FAIL reset_bo: got %b expected %b", b_out, 4'b0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    int vec [4][3] = '{'{7, 3, 0}, '{3, 5, 0}, '{0, 0, 1}, '{8, 1, 0}};
    int lat, bcnt;
    logic ov, to;
    logic [N-1:0] dh;
    for (int v = 0; v < 4; v++) begin
      do_op(vec[v][0], vec[v][1], vec[v][2], lat, bcnt, ov, to);
      checks++; if (to)     begin errors++; $display("FAIL dir%0d_timeout: got no done expected done", v); end
      checks++; if (lat != N+1) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", v, lat, N+1); end
      checks++; if (bcnt != N)  begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", v, bcnt, N); end
      checks++; if (ov)     begin errors++; $display("FAIL dir%0d_busy_done_overlap: got 1 expected 0", v); end
      checks++; if (d !== ref_d(vec[v][0], vec[v][1], vec[v][2]))
        begin errors++; $display("FAIL dir%0d_d: got %b expected %b", v, d, ref_d(vec[v][0], vec[v][1], vec[v][2])); end
      checks++; if (b_out !== ref_bo(vec[v][0], vec[v][1], vec[v][2]))
        begin errors++; $display("FAIL dir%0d_bo: got %b expected %b", v, b_out, ref_bo(vec[v][0], vec[v][1], vec[v][2])); end
`ifdef SERIAL_SUB_OVERFLOW_EN
      checks++; if (ovf !== ref_ovf(vec[v][0], vec[v][1], vec[v][2]))
        begin errors++; $display("FAIL dir%0d_ovf: got %b expected %b", v, ovf, ref_ovf(vec[v][0], vec[v][1], vec[v][2])); end
`endif
      dh = d;
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width: got %b expected 0", v, done); end
      checks++; if (d !== dh)      begin errors++; $display("FAIL dir%0d_d_hold: got %b expected %b", v, d, dh); end
    end
  endtask

  task automatic test_random;
    int x, y, c, lat, bcnt;
    logic ov, to;
    for (int n = 0; n < 40; n++) begin
      x = $urandom_range(0, (1 << N) - 1);
      y = $urandom_range(0, (1 << N) - 1);
      c = $urandom_range(0, 1);
      do_op(x, y, c, lat, bcnt, ov, to);
      checks++; if (to || lat != N+1) begin errors++; $display("FAIL rnd_latency: got %0d expected %0d", lat, N+1); end
      checks++; if (d !== ref_d(x, y, c))
        begin errors++; $display("FAIL rnd_d %0d-%0d-%0d: got %b expected %b", x, y, c, d, ref_d(x, y, c)); end
      checks++; if (b_out !== ref_bo(x, y, c))
        begin errors++; $display("FAIL rnd_bo %0d-%0d-%0d: got %b expected %b", x, y, c, b_out, ref_bo(x, y, c)); end
`ifdef SERIAL_SUB_OVERFLOW_EN
      checks++; if (ovf !== ref_ovf(x, y, c))
        begin errors++; $display("FAIL rnd_ovf %0d-%0d-%0d: got %b expected %b", x, y, c, ovf, ref_ovf(x, y, c)); end
`endif
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    a = 4'd7; b = 4'd3; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    checks++; if (!done) begin errors++; $display("FAIL b2b_first_done: got 0 expected 1"); end
    checks++; if (d !== 4'd4) begin errors++; $display("FAIL b2b_ignored_start_d: got %b expected %b", d, 4'd4); end
    a = 4'd9; b = 4'd2; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || done !== 1'b0)
      begin errors++; $display("FAIL b2b_accept_in_done: got busy=%b done=%b expected busy=1 done=0", busy, done); end
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    start = 1'b0;
    checks++; if (n != N) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", n, N); end
    checks++; if (d !== 4'd7) begin errors++; $display("FAIL b2b_second_d: got %b expected %b", d, 4'd7); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid_run;
    int lat, bcnt;
    logic ov, to, seen;
    @(negedge clk);
    a = 4'd7; b = 4'd3; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (d !== '0 || b_out !== '0)
      begin errors++; $display("FAIL midrst_results: got d=%b bo=%b expected 0", d, b_out); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0)
      begin errors++; $display("FAIL midrst_flags: got busy=%b done=%b ovf=%b expected 0", busy, done, ovf); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_no_done: got activity expected idle"); end
    do_op(12, 5, 1, lat, bcnt, ov, to);
    checks++; if (to || lat != N+1) begin errors++; $display("FAIL midrst_restart_latency: got %0d expected %0d", lat, N+1); end
    checks++; if (d !== ref_d(12, 5, 1))
      begin errors++; $display("FAIL midrst_restart_d: got %b expected %b", d, ref_d(12, 5, 1)); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
